audio_pwm_out: RTL and testbench
================================

# audio_pwm_out

Playback counterpart of the microphone capture path. Buffers 8-bit PCM samples written by the processor-side bus in a small FIFO, then drains them at a fixed sample rate into a 1-bit modulated stream for the board audio amplifier: PWM by default, first-order sigma-delta as a build option. Sits on the same bus as the microphone block and uses the same `wr`-level strobe style; drives the amplifier PWM and shutdown pins.

## Interface
- `DATA_W`, 8: sample width; the phase counter is also this width, so one sample period lasts 2^DATA_W modulator ticks.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `PRESCALE`, 1: clocks per modulator tick, ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `wr`  in  1  write request, level; a write happens once per 0→1 transition.
- `din`  in  DATA_W  unsigned sample, captured on the write cycle.
- `en`  in  1  playback enable.
- `ampPWM`  out  1  modulated audio bit, registered.
- `ampSD`  out  1  amplifier enable (1 = on), registered copy of `en`.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  DEPTH_LOG2+1  FIFO occupancy.
- `underrun`  out  1  sticky: a sample period started with the FIFO empty.

## Operation
- Write detect: `wr_q` registers `wr`; write strobe = `wr & ~wr_q`. A held `wr` writes exactly once. The strobe is accepted with `en` high or low.
- FIFO: circular, read/write pointers DEPTH_LOG2 bits, wrapping naturally. Write when full is dropped; pointers and `count` unchanged. Write and pop on the same clock both happen; `count` unchanged. A pop on an empty FIFO never occurs (see underrun).
- Prescaler: counts 0..PRESCALE-1 while `en`=1; `tick` asserts on the clock it is PRESCALE-1 (every clock when PRESCALE=1).
- Phase counter (DATA_W bits): increments on `tick`. When `tick` and phase = all-ones, phase wraps to 0 and the sample register loads:
  - FIFO non-empty: pop head into `sample`, `count` decrements.
  - FIFO empty: `sample` ← 2^(DATA_W-1) (mid-scale silence), `underrun` ← 1.
- PWM: each clock `ampPWM` ← `en` & (phase < `sample`). Sample 0 → constantly 0; sample S → S high ticks per 2^DATA_W ticks, contiguous from phase 0.
- `en`=0: prescaler ← 0, phase ← all-ones, `sample` ← mid-scale, `ampPWM` ← 0, `ampSD` ← 0. FIFO contents kept. The first tick after `en` rises therefore loads a new sample immediately.
- `underrun` clears on the clock `en` goes 0→1 (registered edge); a set on that same clock wins.

## Timing
- Reset values: `ampPWM`=0, `ampSD`=0, `full`=0, `empty`=1, `count`=0, `underrun`=0; pointers, prescaler, phase=all-ones, `sample`=mid-scale, `wr_q`=0.
- Reset mid-operation flushes the FIFO and stops output asynchronously; nothing resumes until `reset` is released and a tick occurs.
- Write latency: `wr` rises at clock edge n → entry stored and `count`/`empty`/`full` updated after edge n+1.
- Load latency: `sample` and `count` update on the wrap tick edge; `ampPWM` reflects the new sample one clock later.
- `ampSD` follows `en` by one clock.
- Sample rate = f_clk / (PRESCALE · 2^DATA_W).
- `full`, `empty` derive combinationally from the registered `count`.

## Configuration
- `AUDIO_OUT_SIGMADELTA_EN` defined: the PWM comparator is replaced by a first-order sigma-delta modulator. DATA_W+1-bit accumulator; on each `tick`, acc ← acc[DATA_W-1:0] + `sample`; `ampPWM` ← `en` & acc carry bit (bit DATA_W) of the new sum, registered. Accumulator clears on reset and while `en`=0. Sample S still gives exactly S ones per 2^DATA_W ticks, spread evenly.
- Undefined (default): PWM as in Operation; no accumulator logic.

## Test plan
- Reset: assert `reset` mid-playback with `count`=5 → all outputs at reset values immediately, `count`=0, `empty`=1.
- Hold `wr`=1 for 1500 ns with `din`=0x3C → exactly one entry, `count`=1; `wr` 0→1 again → `count`=2.
- Write 0x00, 0x80, 0xFF (`en`=0, PRESCALE=1), raise `en` → successive 256-clock periods show 0, 128, 255 high cycles on `ampPWM`; `count` 3→2→1→0 at each wrap; `underrun` stays 0 through the third period.
- Write 17 samples 1..17 → `full`=1 after the 16th, `count`=16, 17th dropped; playback pops 1 first and 16 last.
- Empty FIFO, `en`=1 → `underrun`=1 after the first wrap, `ampPWM` duty 128/256; drop then raise `en` → `underrun`=0.
- `AUDIO_OUT_SIGMADELTA_EN` build, sample 0x40, PRESCALE=1 → exactly 64 ones per 256 clocks on `ampPWM`, one every 4th clock.

Source files
------------

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers bus-written PCM samples in a small FIFO and plays
// them out at a fixed sample rate as a 1-bit stream for the audio amplifier.
// Default modulator is PWM; defining AUDIO_OUT_SIGMADELTA_EN swaps in a
// first-order sigma-delta modulator instead.
module audio_pwm_out #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int PRESCALE   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [DATA_W-1:0]     din,
   input  logic                  en,
   output logic                  ampPWM,
   output logic                  ampSD,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  underrun
);

   localparam int                 DEPTH   = 1 << DEPTH_LOG2;
   localparam int                 PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]    PS_LOAD = PS_W'(PRESCALE - 1);
   localparam logic [DATA_W-1:0]  MID     = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]  PH_MAX  = '1;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

   logic                  wr_q;
   logic                  en_q;
   logic [PS_W-1:0]       presc_q, presc_d;
   logic [DATA_W-1:0]     phase_q, phase_d;
   logic [DATA_W-1:0]     sample_q, sample_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  underrun_q, underrun_d;
   logic                  pwm_q, pwm_d;
   logic [DATA_W-1:0]     mem_q [DEPTH];

   logic wr_stb, push, pop, tick, wrap, en_rise, mod_bit;

   assign wr_stb  = wr & ~wr_q;
   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign push    = wr_stb & ~full;
   assign tick    = en & (presc_q == '0);
   assign wrap    = tick & (phase_q == PH_MAX);
   assign pop     = wrap & ~empty;
   assign en_rise = en & ~en_q;

   assign ampPWM   = pwm_q;
   assign ampSD    = en_q;
   assign count    = count_q;
   assign underrun = underrun_q;

   // Tick timer, phase counter, sample load and FIFO bookkeeping
   always_comb begin
      presc_d    = presc_q;
      phase_d    = phase_q;
      sample_d   = sample_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      underrun_d = underrun_q;

      // Down-counter reloads on terminal count; held at load value while disabled
      // so the first tick after enable lands PRESCALE clocks later.
      if (!en || presc_q == '0) begin
         presc_d = PS_LOAD;
      end else begin
         presc_d = presc_q - 1'b1;
      end

      if (!en) begin
         phase_d  = PH_MAX;
         sample_d = MID;
      end else if (tick) begin
         phase_d = phase_q + 1'b1;
         if (wrap) begin
            sample_d = empty ? MID : mem_q[rd_ptr_q];
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A new underrun on the enable edge takes priority over the clear.
      if (en_rise) begin
         underrun_d = 1'b0;
      end
      if (wrap && empty) begin
         underrun_d = 1'b1;
      end
   end

`ifdef AUDIO_OUT_SIGMADELTA_EN
   logic [DATA_W:0] acc_q, acc_d, acc_sum;

   // Sigma-delta accumulator; the carry out of each new sum is the output bit
   always_comb begin
      acc_sum = {1'b0, acc_q[DATA_W-1:0]} + {1'b0, sample_q};
      acc_d   = acc_q;
      if (!en) begin
         acc_d = '0;
      end else if (tick) begin
         acc_d = acc_sum;
      end
      mod_bit = acc_d[DATA_W];
   end

   // Accumulator register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   // PWM comparator: high for the first 'sample' phases of each period
   always_comb begin
      mod_bit = (phase_q < sample_q);
   end
`endif

   // Output bit is forced low whenever playback is disabled
   always_comb begin
      pwm_d = en & mod_bit;
   end

   // Control and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q       <= 1'b0;
         en_q       <= 1'b0;
         presc_q    <= PS_LOAD;
         phase_q    <= PH_MAX;
         sample_q   <= MID;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         underrun_q <= 1'b0;
         pwm_q      <= 1'b0;
      end else begin
         wr_q       <= wr;
         en_q       <= en;
         presc_q    <= presc_d;
         phase_q    <= phase_d;
         sample_q   <= sample_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         underrun_q <= underrun_d;
         pwm_q      <= pwm_d;
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out (DATA_W=8, DEPTH_LOG2=4, PRESCALE=1).
// The sigma-delta section is compiled only with AUDIO_OUT_SIGMADELTA_EN.
module tb_audio_pwm_out;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr;
   logic [7:0] din;
   logic       en;
   logic       ampPWM, ampSD, full, empty, underrun;
   logic [4:0] count;

   int vec  = 0;
   int errs = 0;
   int highs;

   audio_pwm_out #(.DATA_W(8), .DEPTH_LOG2(4), .PRESCALE(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .din      (din),
      .en       (en),
      .ampPWM   (ampPWM),
      .ampSD    (ampSD),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic write_sample(input logic [7:0] d);
      din = d;
      wr  = 1'b1;
      step();
      wr  = 1'b0;
      step();
   endtask

   task automatic run_period(output int h);
      h = 0;
      repeat (256) begin
         step();
         h += int'(ampPWM);
      end
   endtask

   initial begin
      reset = 1'b1;
      wr    = 1'b0;
      din   = 8'h00;
      en    = 1'b0;
      repeat (3) step();

      // reset values
      check("rst_ampPWM", ampPWM, 0);
      check("rst_ampSD", ampSD, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_underrun", underrun, 0);
      reset = 1'b0;
      step();

      // held wr writes once; a new rising edge writes again
      din = 8'h3C;
      wr  = 1'b1;
      repeat (150) step();
      check("held_wr_count", count, 1);
      wr = 1'b0;
      step();
      wr = 1'b1;
      step();
      check("rewr_count", count, 2);
      wr = 1'b0;
      step();

      // start playback, top up to 5 entries, then reset mid-playback
      en = 1'b1;
      step();
      check("first_pop_count", count, 1);
      for (int i = 0; i < 4; i++) write_sample(8'h11);
      check("mid_count5", count, 5);
      repeat (20) step();
      check("mid_ampPWM", ampPWM, 1);
      check("mid_ampSD", ampSD, 1);
      #2 reset = 1'b1;
      #1;
      check("async_ampPWM", ampPWM, 0);
      check("async_ampSD", ampSD, 0);
      check("async_count", count, 0);
      check("async_empty", empty, 1);
      check("async_full", full, 0);
      check("async_underrun", underrun, 0);
      en = 1'b0;
      step();
      reset = 1'b0;
      step();

      // duty: 0x00, 0x80, 0xFF then mid-scale on underrun
      write_sample(8'h00);
      write_sample(8'h80);
      write_sample(8'hFF);
      check("duty_count3", count, 3);
      en = 1'b1;
      step();
      check("duty_count2", count, 2);
      run_period(highs);
      check("duty_p0_highs", highs, 0);
      check("duty_count1", count, 1);
      check("duty_ur_p1", underrun, 0);
      run_period(highs);
      check("duty_p1_highs", highs, 128);
      check("duty_count0", count, 0);
      check("duty_ur_p2", underrun, 0);
      highs = 0;
      repeat (255) begin
         step();
         highs += int'(ampPWM);
      end
      check("duty_ur_p3_end", underrun, 0);
      step();
      highs += int'(ampPWM);
      check("duty_p2_highs", highs, 255);
      check("ur_set", underrun, 1);
      check("ur_count", count, 0);
      run_period(highs);
      check("ur_mid_highs", highs, 128);

      // disable, underrun sticky; re-enable with data clears it
      en = 1'b0;
      step();
      check("dis_ampSD", ampSD, 0);
      check("dis_ampPWM", ampPWM, 0);
      check("dis_ur_sticky", underrun, 1);
      write_sample(8'h10);
      check("dis_count1", count, 1);
      en = 1'b1;
      step();
      check("ur_cleared", underrun, 0);
      check("reen_count0", count, 0);
      en = 1'b0;
      step();

      // fill: 17 writes, last dropped; playback order 1..16
      for (int i = 1; i <= 15; i++) write_sample(8'(i));
      check("fill15_full", full, 0);
      check("fill15_count", count, 15);
      write_sample(8'd16);
      check("fill16_full", full, 1);
      check("fill16_count", count, 16);
      check("fill16_empty", empty, 0);
      write_sample(8'd17);
      check("fill17_count", count, 16);
      en = 1'b1;
      step();
      check("fill_pop_count", count, 15);
      for (int k = 1; k <= 16; k++) begin
         run_period(highs);
         check($sformatf("fill_p%0d_highs", k), highs, k);
      end
      check("fill_drain_count", count, 0);
      check("fill_drain_ur", underrun, 1);
      en = 1'b0;
      step();

`ifdef AUDIO_OUT_SIGMADELTA_EN
      begin
         int ones = 0;
         int last = -1;
         int bad  = 0;
         reset = 1'b1;
         step();
         reset = 1'b0;
         step();
         write_sample(8'h40);
         en = 1'b1;
         step();
         for (int i = 0; i < 256; i++) begin
            step();
            if (ampPWM) begin
               if (last >= 0 && (i - last) != 4) bad++;
               last = i;
               ones++;
            end
         end
         check("sd_ones", ones, 64);
         check("sd_spacing_bad", bad, 0);
         en = 1'b0;
         step();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
